// File: rtl/sram_word_controller.sv
// Splits one 32-bit load/store into two 16-bit SRAM accesses plus fixed settle time.
// Optional SRAM_RANGE_GUARD_EN: out-of-window requests complete without touching the SRAM.
module sram_word_controller #(
   parameter int BASE_ADDR   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N
);
   typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   state_t        state, state_nx;
   logic [CW-1:0] wait_cnt;
   logic [16:0]   word_q;
   logic          op_wr_q;
   logic [15:0]   wdata_hi_q;
   logic          req;
   logic [31:0]   offset;
   logic          out_of_range;
   logic          dq_drive;
   logic [15:0]   dq_out;
   logic          unused_bits;

   assign req    = rd_en | wr_en;
   assign offset = address - 32'(BASE_ADDR);

`ifdef SRAM_RANGE_GUARD_EN
   // Window is 2^17 words above BASE_ADDR; any higher offset bit means outside.
   assign out_of_range = (address < 32'(BASE_ADDR)) || (offset[31:19] != 13'd0);
`else
   assign out_of_range = 1'b0;
`endif

   // Alignment bits and (unguarded) high offset bits are intentionally ignored.
   assign unused_bits = ^{offset[31:19], offset[1:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         word_q     <= '0;
         op_wr_q    <= 1'b0;
         wdata_hi_q <= '0;
         readData   <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (state == IDLE && req) begin
            op_wr_q <= wr_en;
            word_q  <= offset[18:2];
            if (out_of_range && !wr_en)
               readData <= '0;
         end
         if (state == ACC_LO) begin
            if (op_wr_q) wdata_hi_q     <= writeData[31:16];
            else         readData[15:0] <= SRAM_DQ;
         end
         if (state == ACC_HI && !op_wr_q)
            readData[31:16] <= SRAM_DQ;
      end
   end

   always_comb begin
      state_nx  = state;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      dq_drive  = 1'b0;
      case (state)
         IDLE:    if (req) state_nx = out_of_range ? DONE : ACC_LO;
         ACC_LO:  state_nx = ACC_HI;
         ACC_HI:  state_nx = (WAIT_CYCLES == 0) ? DONE : WAIT;
         WAIT:    if (wait_cnt == CW'(WAIT_CYCLES - 1)) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (state == ACC_LO || state == ACC_HI) begin
         SRAM_WE_N = ~op_wr_q;
         SRAM_OE_N = op_wr_q;
         dq_drive  = op_wr_q;
      end
   end

   // Low half comes straight from the port; high half was captured leaving ACC_LO.
   assign dq_out    = (state == ACC_HI) ? wdata_hi_q : writeData[15:0];
   assign SRAM_DQ   = dq_drive ? dq_out : 16'hzzzz;
   assign SRAM_ADDR = {word_q, state == ACC_HI};
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign ready     = ~req | (state == DONE);
endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances, each on its own SRAM model.
module tb_sram_word_controller;
   localparam int BASE = 1024;
`ifdef SRAM_RANGE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  wr_en, rd_en, ready, we_n, oe_n, ub_n, lb_n, ce_n;
   logic [31:0] address [2];
   logic [31:0] wdata   [2];
   logic [31:0] rdata   [2];
   logic [17:0] sram_addr [2];
   wire  [15:0] dq0, dq1;
   logic [15:0] mem0 [0:262143];
   logic [15:0] mem1 [0:262143];

   sram_word_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
      .writeData(wdata[0]), .readData(rdata[0]), .ready(ready[0]), .SRAM_DQ(dq0),
      .SRAM_ADDR(sram_addr[0]), .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]),
      .SRAM_CE_N(ce_n[0]), .SRAM_WE_N(we_n[0]), .SRAM_OE_N(oe_n[0]));

   sram_word_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
      .writeData(wdata[1]), .readData(rdata[1]), .ready(ready[1]), .SRAM_DQ(dq1),
      .SRAM_ADDR(sram_addr[1]), .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]),
      .SRAM_CE_N(ce_n[1]), .SRAM_WE_N(we_n[1]), .SRAM_OE_N(oe_n[1]));

   // SRAM models: write on the clock while WE_N is low, drive the bus while OE_N is low.
   always @(posedge clk) if (!we_n[0]) mem0[sram_addr[0]] <= dq0;
   always @(posedge clk) if (!we_n[1]) mem1[sram_addr[1]] <= dq1;
   assign dq0 = (!oe_n[0] && we_n[0]) ? mem0[sram_addr[0]] : 16'hzzzz;
   assign dq1 = (!oe_n[1] && we_n[1]) ? mem1[sram_addr[1]] : 16'hzzzz;

   typedef struct {
      int          dut;
      logic        wr, rd;
      logic [31:0] addr, wdat, exp_rdata;
      int          exp_lat, exp_strobes;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      int          lat, strobes;
      logic [17:0] a_lo, a_hi;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[12];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_one(input int idx, input vec_t v);
      exp_t        e;
      int          cyc, ns;
      bit          done;
      logic [17:0] alo, ahi;
      logic [31:0] off;
      off       = v.addr - BASE;
      e.rdata   = v.exp_rdata;
      e.lat     = v.exp_lat;
      e.strobes = v.exp_strobes;
      e.a_lo    = {off[18:2], 1'b0};
      e.a_hi    = {off[18:2], 1'b1};
      sb.push_back(e);
      @(posedge clk); #1;
      wr_en[v.dut] = v.wr; rd_en[v.dut] = v.rd;
      address[v.dut] = v.addr; wdata[v.dut] = v.wdat;
      cyc = 0; ns = 0; alo = '0; ahi = '0; done = 1'b0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         if (!we_n[v.dut] || !oe_n[v.dut]) begin
            if (ns == 0) alo = sram_addr[v.dut];
            else         ahi = sram_addr[v.dut];
            ns++;
         end
         if (ready[v.dut]) done = 1'b1;
         else              cyc++;
      end
      chk($sformatf("v%0d_completed", idx), 32'(done), 32'd1);
      e = sb.pop_front();
      chk($sformatf("v%0d_latency", idx), cyc, e.lat);
      chk($sformatf("v%0d_readData", idx), rdata[v.dut], e.rdata);
      chk($sformatf("v%0d_strobes", idx), ns, e.strobes);
      if (e.strobes == 2) begin
         chk($sformatf("v%0d_addr_lo", idx), 32'(alo), 32'(e.a_lo));
         chk($sformatf("v%0d_addr_hi", idx), 32'(ahi), 32'(e.a_hi));
      end
      @(posedge clk); #1;
      wr_en[v.dut] = 1'b0; rd_en[v.dut] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [11:0] frz;
      int          pulses;
      rst = 1'b0; wr_en = '0; rd_en = '0;
      for (int i = 0; i < 2; i++) begin address[i] = '0; wdata[i] = '0; end

      vecs[0]  = '{0, 1, 0, 32'd1024, 32'hDEADBEEF, 32'h0,        5, 2};
      vecs[1]  = '{0, 0, 1, 32'd1024, 32'h0,        32'hDEADBEEF, 5, 2};
      vecs[2]  = '{0, 1, 0, 32'd1028, 32'h12345678, 32'hDEADBEEF, 5, 2};
      vecs[3]  = '{0, 0, 1, 32'd1028, 32'h0,        32'h12345678, 5, 2};
      vecs[4]  = '{0, 0, 1, 32'd1024, 32'h0,        32'hDEADBEEF, 5, 2};
      vecs[5]  = '{0, 1, 1, 32'd1032, 32'hCAFEF00D, 32'hDEADBEEF, 5, 2};
      vecs[6]  = '{0, 0, 1, 32'd1032, 32'h0,        32'hCAFEF00D, 5, 2};
      vecs[7]  = '{0, 1, 0, 32'd0,    32'hA5A55A5A, 32'hCAFEF00D, GUARD ? 1 : 5, GUARD ? 0 : 2};
      vecs[8]  = '{0, 0, 1, 32'd0,    32'h0, GUARD ? 32'h0 : 32'hA5A55A5A, GUARD ? 1 : 5, GUARD ? 0 : 2};
      vecs[9]  = '{1, 1, 0, 32'd1024, 32'h0BADF00D, 32'h0,        3, 2};
      vecs[10] = '{1, 0, 1, 32'd1024, 32'h0,        32'h0BADF00D, 3, 2};
      vecs[11] = '{1, 1, 1, 32'd1028, 32'h77778888, 32'h0BADF00D, 3, 2};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",   32'(ready), 32'h3);
      chk("rst_we_n",    32'(we_n),  32'h3);
      chk("rst_oe_n",    32'(oe_n),  32'h3);
      chk("rst_addr",    32'(sram_addr[0]), 32'h0);
      chk("rst_rdata",   rdata[0], 32'h0);
      chk("const_pins",  32'({ub_n, lb_n, ce_n}), 32'h0);
      @(negedge clk); rst = 1'b1;

      for (int i = 0; i < 12; i++) run_one(i, vecs[i]);

      chk("mem0_0", 32'(mem0[0]), 32'hBEEF);
      chk("mem0_1", 32'(mem0[1]), 32'hDEAD);
      chk("mem0_2", 32'(mem0[2]), 32'h5678);
      chk("mem0_3", 32'(mem0[3]), 32'h1234);
      chk("mem0_4", 32'(mem0[4]), 32'hF00D);
      chk("mem0_5", 32'(mem0[5]), 32'hCAFE);
      chk("mem1_2", 32'(mem1[2]), 32'h8888);
      chk("mem1_3", 32'(mem1[3]), 32'h7777);
      if (!GUARD) chk("mem0_wrap", 32'(mem0[18'h3FE00]), 32'h5A5A);

      // Back-to-back reads with rd_en held
      pulses = 0;
      @(posedge clk); #1;
      rd_en[0] = 1'b1; address[0] = 32'd1024;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         frz[11-i] = ~ready[0];
         if (!oe_n[0]) pulses++;
      end
      @(posedge clk); #1;
      rd_en[0] = 1'b0;
      chk("b2b_freeze",    32'(frz), 32'(12'b111110111110));
      chk("b2b_oe_pulses", pulses, 4);
      chk("b2b_rdata",     rdata[0], 32'hDEADBEEF);

      // Reset asserted while the low half of a write is on the bus
      @(posedge clk); #1;
      wr_en[0] = 1'b1; address[0] = 32'd1040; wdata[0] = 32'h11112222;
      @(posedge clk); #1;
      chk("midrst_we_low", 32'(we_n[0]), 32'h0);
      #2 rst = 1'b0;
      #1;
      chk("midrst_we_n",  32'(we_n[0]), 32'h1);
      chk("midrst_oe_n",  32'(oe_n[0]), 32'h1);
      chk("midrst_addr",  32'(sram_addr[0]), 32'h0);
      chk("midrst_rdata", rdata[0], 32'h0);
      wr_en[0] = 1'b0;
      @(negedge clk);
      chk("midrst_we_hold", 32'(we_n[0]), 32'h1);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
